spi_flash_responder: RTL and testbench

SPI mode-0 target that emulates the read side of the serial boot flash, serving bytes from a synchronous byte-wide ROM port. It is the far end of the CPU's flash reader: simulation benches and board-level loopback builds place it on SPI_CLK/SPI_CS/SPI_MOSI/SPI_MISO. Supports READ (0x03), FAST READ (0x0B) and JEDEC ID (0x9F) with auto-incrementing streamed data, oversampling the SPI pins with CLK.

---
 rtl/spi_flash_pkg.sv | 20 ++
 rtl/sync_edge.sv | 25 ++
 rtl/spi_flash_responder.sv | 195 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Opcodes, dummy-cycle count and FSM state encoding for the SPI boot-flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_JEDEC_ID  = 8'h9F;

  localparam int DUMMY_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_ID,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with edge detect against a delayed copy; level/edges valid 2 CLK after the pin.
// No flow control; flops are deliberately unreset so the true pin level is visible as reset releases.
module sync_edge (
  input  logic CLK,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge CLK) begin
    meta <= d;
    sync <= meta;
    prev <= sync;
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash read target (READ/FAST READ/JEDEC ID) fed from a byte ROM; pin-to-action 3 CLK.
// No backpressure: the initiator must honour SCK phases >= 4 CLK so ROM fetches land before the next fall.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W   = 17,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rstrb,
  input  logic [7:0]        rom_rdata,
  output logic              busy,
  output logic              cmd_error
);

  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

  logic sck_rise_raw, sck_fall_raw, sck_lvl_unused;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi, mosi_rise_unused, mosi_fall_unused;
  logic sck_rise, sck_fall;

  sync_edge u_sck (
    .CLK   (CLK),
    .d     (spi_clk),
    .level (sck_lvl_unused),
    .rise  (sck_rise_raw),
    .fall  (sck_fall_raw)
  );

  sync_edge u_cs (
    .CLK   (CLK),
    .d     (spi_cs_n),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge u_mosi (
    .CLK   (CLK),
    .d     (spi_mosi),
    .level (mosi),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // Gating on CS level also makes a coincident cs_rise win over any SCK edge.
  assign sck_rise = sck_rise_raw & ~cs_lvl;
  assign sck_fall = sck_fall_raw & ~cs_lvl;

  state_t      state, state_next;
  logic [4:0]  bit_cnt;
  logic [7:0]  cmd_sh;
  logic [7:0]  opcode;
  logic        dummy_flag;
  logic [2:0]  out_cnt;
  logic [7:0]  shift_out;
  logic [7:0]  stage;
  logic [23:0] id_sh;
  logic        rd_pend;
  logic        first_fetch;
  logic        fetch;
  logic        bad_op;

  assign opcode = {cmd_sh[6:0], mosi};

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fetch      = 1'b0;
    bad_op     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_fall)      state_next = ST_CMD;
        else if (!cs_lvl) state_next = ST_IGNORE;
      end
      ST_CMD: begin
        if (sck_rise && bit_cnt == 5'd7) begin
          if (opcode == OP_READ || opcode == OP_FAST_READ) begin
            state_next = ST_ADDR;
          end else if (opcode == OP_JEDEC_ID) begin
            state_next = ST_ID;
          end else begin
            bad_op     = 1'b1;
            state_next = ST_IGNORE;
          end
        end
      end
      ST_ADDR: begin
        if (sck_rise && bit_cnt == 5'd23) begin
          if (dummy_flag) begin
            state_next = ST_DUMMY;
          end else begin
            fetch      = 1'b1;
            state_next = ST_DATA;
          end
        end
      end
      ST_DUMMY: begin
        if (sck_rise && bit_cnt == DUMMY_LAST) begin
          fetch      = 1'b1;
          state_next = ST_DATA;
        end
      end
      default: ;
    endcase
    if (cs_rise) state_next = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      spi_miso    <= 1'b0;
      rom_addr    <= '0;
      rom_rstrb   <= 1'b0;
      busy        <= 1'b0;
      cmd_error   <= 1'b0;
      bit_cnt     <= '0;
      cmd_sh      <= '0;
      dummy_flag  <= 1'b0;
      out_cnt     <= '0;
      shift_out   <= '0;
      stage       <= '0;
      id_sh       <= '0;
      rd_pend     <= 1'b0;
      first_fetch <= 1'b0;
    end else begin
      rom_rstrb <= 1'b0;
      cmd_error <= bad_op;
      busy      <= ~cs_lvl;
      rd_pend   <= rom_rstrb;

      if (state_next != state)
        bit_cnt <= '0;
      else if (sck_rise && (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY))
        bit_cnt <= bit_cnt + 5'd1;

      if (sck_rise) cmd_sh <= opcode;
      if (state == ST_CMD && sck_rise && bit_cnt == 5'd7)
        dummy_flag <= (opcode == OP_FAST_READ);
      if (state == ST_ADDR && sck_rise)
        rom_addr <= {rom_addr[ADDR_W-2:0], mosi};
      if (state == ST_CMD && state_next == ST_ID)
        id_sh <= JEDEC_ID;

      if (fetch) begin
        rom_rstrb   <= 1'b1;
        first_fetch <= 1'b1;
        out_cnt     <= '0;
      end

      // First returned byte goes straight to the shifter and triggers the prefetch of addr+1.
      if (rd_pend && state == ST_DATA) begin
        if (first_fetch) begin
          shift_out   <= rom_rdata;
          first_fetch <= 1'b0;
          rom_addr    <= rom_addr + ADDR_W'(1);
          rom_rstrb   <= 1'b1;
        end else begin
          stage <= rom_rdata;
        end
      end

      if (sck_fall && state == ST_DATA) begin
        spi_miso <= shift_out[7];
        out_cnt  <= out_cnt + 3'd1;
        if (out_cnt == 3'd7) begin
          shift_out <= stage;
          rom_addr  <= rom_addr + ADDR_W'(1);
          rom_rstrb <= 1'b1;
        end else begin
          shift_out <= {shift_out[6:0], 1'b0};
        end
      end

      if (sck_fall && state == ST_ID) begin
        spi_miso <= id_sh[23];
        id_sh    <= {id_sh[22:0], 1'b0};
      end

      if (state_next != ST_DATA && state_next != ST_ID)
        spi_miso <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized SPI-initiator bench for spi_flash_responder with a queue-based scoreboard.
module tb_spi_flash_responder;

  localparam int AW = 17;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          spi_clk = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic [AW-1:0] rom_addr;
  logic          rom_rstrb;
  logic [7:0]    rom_rdata = 8'h00;
  logic          busy;
  logic          cmd_error;

  logic [7:0]    rom [0:(1<<AW)-1];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            exp_err = 0;
  int            err_seen = 0;
  logic [7:0]    rx = 8'h00;
  int            rx_n = 0;

  spi_flash_responder #(.ADDR_W(AW), .JEDEC_ID(24'hEF4016)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .rom_addr  (rom_addr),
    .rom_rstrb (rom_rstrb),
    .rom_rdata (rom_rdata),
    .busy      (busy),
    .cmd_error (cmd_error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (rom_rstrb) rom_rdata <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MISO byte monitor: what a real initiator would capture on SCK rises.
  always @(posedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      rx_n = 0;
    end else begin
      rx = {rx[6:0], spi_miso};
      rx_n++;
      if (rx_n == 8) begin
        rx_n = 0;
        if (exp_q.size() == 0) check("miso_unexpected_byte", {24'd0, rx}, 32'h100);
        else                   check("miso_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ROM strobe and error-pulse monitor.
  always @(negedge CLK) begin
    if (rom_rstrb) begin
      if (addr_q.size() == 0) check("rstrb_unexpected", 32'(rom_addr), 32'hFFFF_FFFF);
      else                    check("rstrb_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
    end
    if (cmd_error) err_seen++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cs_assert();
    spi_cs_n = 1'b0;
    clk_wait(2);
    check("busy_before_sync", 32'(busy), 32'd0);
    clk_wait(1);
    check("busy_after_sync", 32'(busy), 32'd1);
    clk_wait(3);
  endtask

  task automatic cs_release();
    clk_wait(6);
    spi_cs_n = 1'b1;
    clk_wait(10);
  endtask

  task automatic sck_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      clk_wait(6);
      spi_clk = 1'b1;
      clk_wait(6);
      spi_clk = 1'b0;
    end
  endtask

  // The final prefetch after the last completed byte is optional for the initiator.
  task automatic end_txn();
    check("rstrb_shortfall", 32'(addr_q.size() <= 1), 32'd1);
    addr_q.delete();
    check("miso_bytes_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic expect_read(input logic [7:0] op, input logic [23:0] a, input int n);
    logic [AW-1:0] base;
    base = a[AW-1:0];
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    if (op == 8'h0B) exp_q.push_back(8'h00);
    for (int i = 0; i < n; i++) exp_q.push_back(rom[base + AW'(i)]);
    for (int i = 0; i < n + 2; i++) addr_q.push_back(base + AW'(i));
  endtask

  task automatic read_txn(input logic [7:0] op, input logic [23:0] a, input int n);
    expect_read(op, a, n);
    cs_assert();
    sck_bits({24'd0, op}, 8);
    sck_bits({8'd0, a}, 24);
    if (op == 8'h0B) sck_bits($urandom, 8);
    for (int i = 0; i < n; i++) sck_bits($urandom, 8);
    cs_release();
    end_txn();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
    rom[17'h00010] = 8'hDE;
    rom[17'h00011] = 8'hAD;
    rom[17'h00012] = 8'hBE;
    rom[17'h00013] = 8'hEF;
    rom[17'h00004] = 8'h5A;
    rom[17'h1FFFF] = 8'h11;
    rom[17'h00000] = 8'h22;
    rom[17'h00020] = 8'h6C;

    clk_wait(4);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rstrb", 32'(rom_rstrb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_error", 32'(cmd_error), 32'd0);
    reset = 1'b0;
    clk_wait(6);

    read_txn(8'h03, 24'h000010, 4);
    read_txn(8'h0B, 24'h000004, 2);
    read_txn(8'h03, 24'h01FFFF, 2);
    read_txn(8'h03, 24'hFE0003, 1);

    // JEDEC ID then zeros
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h16);
    exp_q.push_back(8'h00);
    cs_assert();
    sck_bits(32'h9F, 8);
    repeat (4) sck_bits($urandom, 8);
    cs_release();
    end_txn();

    // Unsupported opcode: one error pulse, MISO stays low
    exp_err++;
    repeat (4) exp_q.push_back(8'h00);
    cs_assert();
    sck_bits(32'hC7, 8);
    repeat (3) sck_bits($urandom, 8);
    cs_release();
    end_txn();
    check("cmd_error_after_bad_op", 32'(err_seen), 32'(exp_err));
    read_txn(8'h03, 24'($urandom), 2);

    // Abort after 12 address bits, then a clean READ
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    cs_assert();
    sck_bits(32'h03, 8);
    sck_bits(32'h000, 12);
    cs_release();
    end_txn();
    read_txn(8'h03, 24'h000020, 1);
    check("cmd_error_after_abort", 32'(err_seen), 32'(exp_err));

    // Reset in the middle of DATA with CS held low
    expect_read(8'h03, 24'h000100, 2);
    cs_assert();
    sck_bits(32'h03, 8);
    sck_bits(32'h000100, 24);
    repeat (2) sck_bits($urandom, 8);
    clk_wait(6);
    reset = 1'b1;
    clk_wait(3);
    check("reset_mid_miso", 32'(spi_miso), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    clk_wait(4);
    check("post_reset_busy", 32'(busy), 32'd1);
    exp_q.push_back(8'h00);
    sck_bits(32'h03, 8);
    cs_release();
    end_txn();
    read_txn(8'h03, 24'h000100, 2);

    repeat (8) begin
      logic [7:0] op;
      op = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h0B;
      read_txn(op, 24'($urandom), $urandom_range(1, 4));
    end

    clk_wait(10);
    check("cmd_error_total", 32'(err_seen), 32'(exp_err));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
